// File: rtl/panda_pkg.sv
// Shared types and helpers for the panda compare datapath.
// Default sizes match the branch/ALU use: 32-bit operands, two requesters.
package panda_pkg;

  localparam int unsigned CmpWidth  = 32;
  localparam int unsigned CmpNumReq = 2;
  localparam int unsigned CmpIdW    = $clog2(CmpNumReq);

  typedef struct packed {
    logic [CmpWidth-1:0] op_a;
    logic [CmpWidth-1:0] op_b;
    logic                sign;
  } cmp_req_t;

  typedef struct packed {
    logic [CmpIdW-1:0]   id;
    logic [CmpWidth-1:0] diff;
    logic                equal;
    logic                less;
  } cmp_rsp_t;

  // When the operand MSBs differ the subtraction may overflow, so the
  // ordering comes from the MSBs alone; otherwise the difference sign is exact.
  function automatic logic cmp_less(input logic a_msb, input logic b_msb,
                                    input logic diff_msb, input logic sign);
    logic res;
    if (a_msb != b_msb) begin
      res = sign ? a_msb : b_msb;
    end else begin
      res = diff_msb;
    end
    return res;
  endfunction

endpackage

// File: rtl/panda_adder.sv
// Width-bit adder/subtractor: sum = a + b, or a + ~b + 1 when subtracting.
module panda_adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] b_eff;
  logic [Width-1:0] cin;

  always_comb begin
    b_eff = b_i ^ {Width{subtract_i}};
    cin   = {{(Width-1){1'b0}}, subtract_i};
    sum_o = a_i + b_eff + cin;
  end

endmodule

// File: rtl/panda_comparator_sub.sv
// Derives equal/less flags from a subtraction result and the operand MSBs.
module panda_comparator_sub
  import panda_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  input  logic [Width-1:0] diff_i,
  input  logic             sign_i,
  output logic             equal_o,
  output logic             less_o
);

  always_comb begin
    equal_o = (diff_i == '0);
    less_o  = cmp_less(a_msb_i, b_msb_i, diff_i[Width-1], sign_i);
  end

endmodule

// File: rtl/panda_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping.
module panda_rr_arbiter #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    idx_o,
  output logic              any_o
);

  int unsigned r;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    r     = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      r = (32'(ptr_i) + off) % NumReq;
      if (!any_o && valid_i[r]) begin
        any_o    = 1'b1;
        gnt_o[r] = 1'b1;
        idx_o    = IdW'(r);
      end
    end
  end

endmodule

// File: rtl/panda_compare_arbiter.sv
// Shares one subtract/compare datapath between NumReq requesters with round-robin
// arbitration and a single registered response slot under valid/ready flow control.
module panda_compare_arbiter
  import panda_pkg::*;
#(
  parameter  int unsigned Width  = CmpWidth,
  parameter  int unsigned NumReq = CmpNumReq,
  localparam int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq-1:0][Width-1:0] req_op_a_i,
  input  logic [NumReq-1:0][Width-1:0] req_op_b_i,
  input  logic [NumReq-1:0]            req_sign_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [IdW-1:0]               rsp_id_o,
  output logic [Width-1:0]             rsp_diff_o,
  output logic                         rsp_equal_o,
  output logic                         rsp_less_o
);

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [Width-1:0] diff;
    logic             equal;
    logic             less;
  } rsp_t;

  logic [IdW-1:0]    ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  rsp_t              rsp_q, rsp_d;

  logic [NumReq-1:0] gnt;
  logic [IdW-1:0]    win_idx;
  logic              win_any;
  logic              can_accept;
  logic              xfer;

  logic [Width-1:0]  op_a_sel, op_b_sel;
  logic              sign_sel;
  logic [Width-1:0]  diff;
  logic              equal, less;

  panda_rr_arbiter #(
    .NumReq(NumReq)
  ) u_arb (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (win_idx),
    .any_o  (win_any)
  );

  always_comb begin
    op_a_sel = req_op_a_i[win_idx];
    op_b_sel = req_op_b_i[win_idx];
    sign_sel = req_sign_i[win_idx];
  end

  panda_adder #(
    .Width(Width)
  ) u_adder (
    .a_i       (op_a_sel),
    .b_i       (op_b_sel),
    .subtract_i(1'b1),
    .sum_o     (diff)
  );

  panda_comparator_sub #(
    .Width(Width)
  ) u_cmp (
    .a_msb_i(op_a_sel[Width-1]),
    .b_msb_i(op_b_sel[Width-1]),
    .diff_i (diff),
    .sign_i (sign_sel),
    .equal_o(equal),
    .less_o (less)
  );

  // A draining slot can be refilled in the same cycle.
  always_comb begin
    can_accept  = !rsp_valid_q || rsp_ready_i;
    xfer        = can_accept && win_any;
    req_ready_o = gnt & {NumReq{can_accept && rst_ni}};

    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_d.id    = win_idx;
      rsp_d.diff  = diff;
      rsp_d.equal = equal;
      rsp_d.less  = less;
      ptr_d       = (win_idx == IdW'(NumReq - 1)) ? '0 : win_idx + IdW'(1);
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  always_comb begin
    rsp_valid_o = rsp_valid_q;
    rsp_id_o    = rsp_q.id;
    rsp_diff_o  = rsp_q.diff;
    rsp_equal_o = rsp_q.equal;
    rsp_less_o  = rsp_q.less;
  end

endmodule

// File: tb/tb_panda_compare_arbiter.sv
// Directed table-driven bench for panda_compare_arbiter (Width=32, NumReq=2).
module tb_panda_compare_arbiter;
  import panda_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_op_a_i;
  logic [1:0][31:0] req_op_b_i;
  logic [1:0]       req_sign_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [0:0]       rsp_id_o;
  logic [31:0]      rsp_diff_o;
  logic             rsp_equal_o;
  logic             rsp_less_o;

  int checks = 0;
  int errors = 0;

  panda_compare_arbiter #(
    .Width (32),
    .NumReq(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_op_a_i (req_op_a_i),
    .req_op_b_i (req_op_b_i),
    .req_sign_i (req_sign_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_id_o   (rsp_id_o),
    .rsp_diff_o (rsp_diff_o),
    .rsp_equal_o(rsp_equal_o),
    .rsp_less_o (rsp_less_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0, b0;
    logic        s0;
    logic [31:0] a1, b1;
    logic        s1;
    logic        rdy;
    logic [1:0]  exp_ready;
    logic        exp_vld;
    cmp_rsp_t    exp_rsp;
  } vec_t;

  localparam logic [31:0] M123   = 32'hFFFF_FF85;  // -123
  localparam logic [31:0] M23423 = 32'hFFFF_A481;  // -23423
  localparam logic [31:0] P23423 = 32'h0000_5B7F;  // +23423

  vec_t vecs[17];

  function automatic vec_t mk(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                              input logic s0, input logic [31:0] a1, input logic [31:0] b1,
                              input logic s1, input logic rdy, input logic [1:0] exp_ready,
                              input logic exp_vld, input logic exp_id, input logic [31:0] exp_diff,
                              input logic exp_eq, input logic exp_less);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.a1 = a1; v.b1 = b1; v.s1 = s1; v.rdy = rdy;
    v.exp_ready     = exp_ready;
    v.exp_vld       = exp_vld;
    v.exp_rsp.id    = exp_id;
    v.exp_rsp.diff  = exp_diff;
    v.exp_rsp.equal = exp_eq;
    v.exp_rsp.less  = exp_less;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic vld, input logic id, input logic [31:0] diff,
                         input logic eq, input logic less);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(vld));
    chk({tag, ".rsp_id"},    64'(rsp_id_o),    64'(id));
    chk({tag, ".rsp_diff"},  64'(rsp_diff_o),  64'(diff));
    chk({tag, ".rsp_equal"}, 64'(rsp_equal_o), 64'(eq));
    chk({tag, ".rsp_less"},  64'(rsp_less_o),  64'(less));
  endtask

  initial begin
    // Pointer state implied by each row is noted at the right (ptr before the row).
    vecs[0]  = mk(2'b01, 2342, 53493, 0, 0, 0, 0, 1, 2'b01, 1, 0, 32'hFFFF_3831, 0, 1); // p0
    vecs[1]  = mk(2'b11, M123, M23423, 1, M123, M23423, 0, 1, 2'b10, 1, 1, 32'h0000_5B04, 0, 0);
    vecs[2]  = mk(2'b11, M123, M23423, 1, M123, M23423, 0, 1, 2'b01, 1, 0, 32'h0000_5B04, 0, 0);
    vecs[3]  = mk(2'b11, M123, P23423, 1, M123, P23423, 0, 1, 2'b10, 1, 1, 32'hFFFF_A406, 0, 0);
    vecs[4]  = mk(2'b11, M123, P23423, 1, M123, P23423, 0, 1, 2'b01, 1, 0, 32'hFFFF_A406, 0, 1);
    vecs[5]  = mk(2'b10, 0, 0, 0, M23423, M23423, 1, 1, 2'b10, 1, 1, 32'h0, 1, 0);        // p1
    vecs[6]  = mk(2'b01, 32'h8000_0000, 1, 1, 0, 0, 0, 1, 2'b01, 1, 0, 32'h7FFF_FFFF, 0, 1);
    vecs[7]  = mk(2'b11, 10, 3, 0, 3, 10, 0, 1, 2'b10, 1, 1, 32'hFFFF_FFF9, 0, 1);        // p1
    vecs[8]  = mk(2'b11, 10, 3, 0, 3, 10, 0, 1, 2'b01, 1, 0, 32'h7, 0, 0);                // p0
    vecs[9]  = mk(2'b11, 10, 3, 0, 3, 10, 0, 0, 2'b00, 1, 0, 32'h7, 0, 0);                // stall
    vecs[10] = mk(2'b11, 10, 3, 0, 3, 10, 0, 0, 2'b00, 1, 0, 32'h7, 0, 0);
    vecs[11] = mk(2'b11, 10, 3, 0, 3, 10, 0, 0, 2'b00, 1, 0, 32'h7, 0, 0);
    vecs[12] = mk(2'b11, 10, 3, 0, 3, 10, 0, 1, 2'b10, 1, 1, 32'hFFFF_FFF9, 0, 1);        // p1
    vecs[13] = mk(2'b00, 10, 3, 0, 3, 10, 0, 1, 2'b00, 0, 1, 32'hFFFF_FFF9, 0, 1);        // drain
    vecs[14] = mk(2'b00, 10, 3, 0, 3, 10, 0, 0, 2'b00, 0, 1, 32'hFFFF_FFF9, 0, 1);
    vecs[15] = mk(2'b10, 10, 3, 0, 3, 10, 0, 0, 2'b10, 1, 1, 32'hFFFF_FFF9, 0, 1);        // p0
    vecs[16] = mk(2'b01, 10, 3, 0, 3, 10, 0, 0, 2'b00, 1, 1, 32'hFFFF_FFF9, 0, 1);        // full

    // Reset with every requester asking.
    rst_ni      = 1'b0;
    req_valid_i = 2'b11;
    req_op_a_i  = '0;
    req_op_b_i  = '0;
    req_sign_i  = '0;
    rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset.req_ready", 64'(req_ready_o), 64'(2'b00));
    chk_rsp("reset", 0, 0, 32'h0, 0, 0);
    rst_ni = 1'b1;
    #1;
    chk("release.req_ready", 64'(req_ready_o), 64'(2'b01));
    req_valid_i = 2'b00;

    @(posedge clk_i);
    #1;
    for (int i = 0; i < 17; i++) begin
      req_valid_i   = vecs[i].valid;
      req_op_a_i[0] = vecs[i].a0;
      req_op_b_i[0] = vecs[i].b0;
      req_sign_i[0] = vecs[i].s0;
      req_op_a_i[1] = vecs[i].a1;
      req_op_b_i[1] = vecs[i].b1;
      req_sign_i[1] = vecs[i].s1;
      rsp_ready_i   = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d.req_ready", i), 64'(req_ready_o), 64'(vecs[i].exp_ready));
      @(posedge clk_i);
      #1;
      chk_rsp($sformatf("v%0d", i), vecs[i].exp_vld, vecs[i].exp_rsp.id, vecs[i].exp_rsp.diff,
              vecs[i].exp_rsp.equal, vecs[i].exp_rsp.less);
    end

    // Reset while a response is stalled: slot and pointer are discarded.
    rst_ni = 1'b0;
    #1;
    chk("midrst.req_ready", 64'(req_ready_o), 64'(2'b00));
    chk_rsp("midrst", 0, 0, 32'h0, 0, 0);
    @(posedge clk_i);
    #1;
    chk("midrst_hold.rsp_valid", 64'(rsp_valid_o), 64'(1'b0));
    rst_ni      = 1'b1;
    req_valid_i = 2'b11;
    rsp_ready_i = 1'b1;
    #1;
    chk("postrst.req_ready", 64'(req_ready_o), 64'(2'b01));
    @(posedge clk_i);
    #1;
    chk_rsp("postrst", 1, 0, 32'h7, 0, 0);
    req_valid_i = 2'b00;
    @(posedge clk_i);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
